passcode_sender: RTL and testbench

Transmit side of the serial passcode interface. Takes a parallel set of plain decimal passcode digits, encrypts each digit, and shifts the result out bit-serially with a valid/ready handshake and a last-bit marker, in the same bit-stream form (data bit, valid, last) that the ID verification path consumes. Used to enrol or replay a stored patient passcode into the verifier, or to drive it directly in system test.

---
 rtl/passcode_sender.sv | 108 ++++++++++
 tb/tb_passcode_sender.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/passcode_sender.sv
// Passcode transmit path: XOR-encrypts decimal digits and streams them
// out bit-serially, MSB of digit 0 first, with valid/ready and last marker.
module passcode_sender #(
  parameter int         NUM_DIGITS = 4,
  parameter logic [3:0] KEY        = 4'b1010
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Start_In,
  input  logic [4*NUM_DIGITS-1:0] Digit_In,
  input  logic                    Ready_In,
  output logic                    D_Bit_Out,
  output logic                    Valid_Out,
  output logic                    Last_Out,
  output logic                    Busy_Out,
  output logic                    Done_Out,
  output logic                    Error_Out
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] TOP = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  sreg;
  logic [CW-1:0] cnt;
  logic [W-1:0]  load_vec;
  logic          bad;

  // Digit 0 lands in the top nibble so the stream always leaves from sreg MSB.
  always_comb begin
    load_vec = '0;
    bad      = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      load_vec[W-1-4*i -: 4] = Digit_In[4*i +: 4] ^ KEY;
      if (Digit_In[4*i +: 4] > 4'd9) bad = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      D_Bit_Out <= 1'b0;
      Valid_Out <= 1'b0;
      Last_Out  <= 1'b0;
      Busy_Out  <= 1'b0;
      Done_Out  <= 1'b0;
      Error_Out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          Error_Out <= 1'b0;
          if (Start_In) begin
            if (bad) begin
              Error_Out <= 1'b1;
            end else begin
              state     <= SEND;
              sreg      <= load_vec;
              cnt       <= TOP;
              D_Bit_Out <= load_vec[W-1];
              Valid_Out <= 1'b1;
              Busy_Out  <= 1'b1;
              Last_Out  <= (TOP == '0);
            end
          end
        end
        SEND: begin
          if (Ready_In) begin
            if (cnt == '0) begin
              state     <= DONE;
              Valid_Out <= 1'b0;
              Last_Out  <= 1'b0;
              D_Bit_Out <= 1'b0;
              Done_Out  <= 1'b1;
            end else begin
              sreg      <= {sreg[W-2:0], 1'b0};
              cnt       <= cnt - 1'b1;
              D_Bit_Out <= sreg[W-2];
              Last_Out  <= (cnt == CW'(1));
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          Done_Out <= 1'b0;
          Busy_Out <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          Valid_Out <= 1'b0;
          Last_Out  <= 1'b0;
          Busy_Out  <= 1'b0;
          Done_Out  <= 1'b0;
          Error_Out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_passcode_sender.sv
// Bench for passcode_sender: directed and random passcodes checked
// against a digit-level model of the encrypted serial stream.
module tb_passcode_sender;

  localparam int         N   = 4;
  localparam int         W   = 4 * N;
  localparam logic [3:0] KEY = 4'b1010;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         Start_In;
  logic [W-1:0] Digit_In;
  logic         Ready_In;
  logic         D_Bit_Out;
  logic         Valid_Out;
  logic         Last_Out;
  logic         Busy_Out;
  logic         Done_Out;
  logic         Error_Out;

  int n_vec = 0;
  int n_err = 0;

  passcode_sender #(.NUM_DIGITS(N), .KEY(KEY)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start_In  (Start_In),
    .Digit_In  (Digit_In),
    .Ready_In  (Ready_In),
    .D_Bit_Out (D_Bit_Out),
    .Valid_Out (Valid_Out),
    .Last_Out  (Last_Out),
    .Busy_Out  (Busy_Out),
    .Done_Out  (Done_Out),
    .Error_Out (Error_Out)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {D_Bit_Out, Valid_Out, Last_Out, Busy_Out, Done_Out, Error_Out};
  endfunction

  // Expected stream: each digit encrypted, sent digit 0 first, bit 3 first.
  function automatic void model(input logic [W-1:0] dig, output logic q[$]);
    logic [3:0] e;
    q = {};
    for (int d = 0; d < N; d++) begin
      e = dig[4*d +: 4] ^ KEY;
      for (int b = 3; b >= 0; b--) q.push_back(e[b]);
    end
  endfunction

  function automatic logic [W-1:0] rand_digits();
    logic [W-1:0] v;
    for (int d = 0; d < N; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // mode 0: always ready, 1: directed stalls, 2: random ready
  task automatic send(input logic [W-1:0] dig, input int mode,
                      input bit poke, input string tag);
    logic exp_q[$];
    int   k = 0, cyc = 0, stalls = 0, s5 = 0, sl = 0;
    logic rdy;
    model(dig, exp_q);
    Start_In = 1'b1;
    Digit_In = dig;
    Ready_In = 1'b1;
    @(negedge Clk);
    Start_In = 1'b0;
    while (k < W && cyc < 200) begin
      chk({tag, "_valid"}, 32'(Valid_Out), 1);
      chk({tag, "_bit"}, 32'(D_Bit_Out), 32'(exp_q[k]));
      chk({tag, "_last"}, 32'(Last_Out), 32'(k == W - 1));
      chk({tag, "_busy"}, 32'(Busy_Out), 1);
      chk({tag, "_done"}, 32'(Done_Out), 0);
      rdy = 1'b1;
      if (mode == 1 && k == 5 && s5 < 3) begin rdy = 1'b0; s5++; end
      if (mode == 1 && k == W - 1 && sl < 2) begin rdy = 1'b0; sl++; end
      if (mode == 2) rdy = 1'($urandom_range(0, 1));
      if (!rdy) stalls++;
      Ready_In = rdy;
      Start_In = poke && (k == 8);
      Digit_In = poke ? rand_digits() : dig;
      @(negedge Clk);
      if (rdy) k++;
      cyc++;
    end
    Start_In = 1'b0;
    chk({tag, "_complete"}, 32'(k), 32'(W));
    chk({tag, "_length"}, 32'(cyc), 32'(W + stalls));
    chk({tag, "_done_cyc"}, 32'({Valid_Out, Busy_Out, Done_Out}), 32'b011);
    Start_In = poke;
    Digit_In = rand_digits();
    @(negedge Clk);
    Start_In = 1'b0;
    chk({tag, "_idle"}, 32'(outs()), 0);
  endtask

  task automatic reject(input logic [W-1:0] dig, input string tag);
    Start_In = 1'b1;
    Digit_In = dig;
    @(negedge Clk);
    Start_In = 1'b0;
    chk({tag, "_err"}, 32'({Valid_Out, Busy_Out, Error_Out}), 32'b001);
    @(negedge Clk);
    chk({tag, "_after"}, 32'(outs()), 0);
  endtask

  initial begin
    logic [W-1:0] dig;
    Rst      = 1'b0;
    Start_In = 1'b0;
    Digit_In = '0;
    Ready_In = 1'b0;
    #12;
    chk("reset_outs", 32'(outs()), 0);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    chk("post_reset", 32'(outs()), 0);

    send(16'h4321, 0, 1'b0, "nominal");
    send(16'h4321, 1, 1'b0, "stall");
    reject(16'h43A1, "bad_digit");
    send(16'h4321, 0, 1'b0, "after_err");
    send(16'h9078, 0, 1'b1, "ignore_start");

    // abort after seven accepted bits
    Start_In = 1'b1;
    Digit_In = 16'h5555;
    Ready_In = 1'b1;
    @(negedge Clk);
    Start_In = 1'b0;
    repeat (7) @(negedge Clk);
    chk("pre_abort_valid", 32'(Valid_Out), 1);
    #2 Rst = 1'b0;
    #1 chk("abort_outs", 32'(outs()), 0);
    @(negedge Clk);
    chk("abort_held", 32'(outs()), 0);
    Rst = 1'b1;
    @(negedge Clk);
    send(16'h4321, 0, 1'b0, "after_abort");

    for (int t = 0; t < 8; t++) begin
      dig = rand_digits();
      if ($urandom_range(0, 3) == 0) begin
        dig[4*$urandom_range(0, N-1) +: 4] = 4'($urandom_range(10, 15));
        reject(dig, "rnd_bad");
      end else begin
        send(dig, 2, 1'($urandom_range(0, 1)), "rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
